// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock sequencing controller.
// Relock-by-key behaviour is selected with the LOCK_RELOCK_KEY_EN macro in lock_ctrl.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_CHECK  = 2'd1,
        ST_OPEN   = 2'd2,
        ST_ALARM  = 2'd3
    } lock_state_e;

    localparam int CLK_HZ    = 50000000;
    localparam int OPEN_SEC  = 1;
    localparam int ALARM_SEC = 5;
    localparam int FAIL_W    = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Entry/status bundle between the key front end, the lock controller and the LEDs.
// The front end (master) drives enter_trig/com_result; the controller (slave) drives the status.
interface lock_ctrl_if;
    import lock_pkg::*;

    logic              enter_trig;
    logic              com_result;
    logic              unlock;
    logic              alarm;
    logic [FAIL_W-1:0] fail_cnt;
    lock_state_e       state;
    logic              busy;

    modport master (
        output enter_trig, com_result,
        input  unlock, alarm, fail_cnt, state, busy
    );

    modport slave (
        input  enter_trig, com_result,
        output unlock, alarm, fail_cnt, state, busy
    );

endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter for the open/alarm hold times; stops at zero, never wraps.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Lock sequencing FSM: entry check, consecutive-failure count, alarm lockout, auto-relock.
// Define LOCK_RELOCK_KEY_EN to let enter_trig relock the door manually while OPEN.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int OPEN_CYCLES  = CLK_HZ * OPEN_SEC,
    parameter int ALARM_CYCLES = CLK_HZ * ALARM_SEC,
    parameter int MAX_FAIL     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    lock_ctrl_if.slave   bus
);

    localparam int TW = $clog2(max2(OPEN_CYCLES, ALARM_CYCLES));

    lock_state_e       state_q, state_d;
    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
    logic              unlock_q, alarm_q, busy_q;
    logic              t_load, t_en, t_zero;
    logic [TW-1:0]     t_val;

    lock_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (t_load),
        .value_i (t_val),
        .en_i    (t_en),
        .zero_o  (t_zero)
    );

    assign t_en = (state_q == ST_OPEN) || (state_q == ST_ALARM);

    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        t_load     = 1'b0;
        t_val      = '0;
        case (state_q)
            ST_LOCKED: begin
                if (bus.enter_trig) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.com_result) begin
                    state_d    = ST_OPEN;
                    fail_cnt_d = '0;
                    t_load     = 1'b1;
                    t_val      = TW'(OPEN_CYCLES - 1);
                end else if (int'(fail_cnt_q) + 1 >= MAX_FAIL) begin
                    state_d    = ST_ALARM;
                    fail_cnt_d = FAIL_W'(MAX_FAIL);
                    t_load     = 1'b1;
                    t_val      = TW'(ALARM_CYCLES - 1);
                end else begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = fail_cnt_q + 1'b1;
                end
            end
            ST_OPEN: begin
`ifdef LOCK_RELOCK_KEY_EN
                // Manual relock clears the hold timer so the next open starts fresh.
                if (bus.enter_trig || t_zero) begin
                    state_d = ST_LOCKED;
                    t_load  = 1'b1;
                end
`else
                if (t_zero) state_d = ST_LOCKED;
`endif
            end
            ST_ALARM: begin
                if (t_zero) begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = '0;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKED;
            fail_cnt_q <= '0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
            unlock_q   <= (state_d == ST_OPEN);
            alarm_q    <= (state_d == ST_ALARM);
            busy_q     <= (state_d == ST_CHECK) || (state_d == ST_ALARM);
        end
    end

    assign bus.state    = state_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.unlock   = unlock_q;
    assign bus.alarm    = alarm_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random entries against a behavioural model.
module tb_lock_ctrl;

    localparam int OPEN_CYCLES  = 4;
    localparam int ALARM_CYCLES = 6;
    localparam int MAX_FAIL     = 3;

    logic clk;
    logic rst_n;

    lock_ctrl_if bus ();

    lock_ctrl #(
        .OPEN_CYCLES  (OPEN_CYCLES),
        .ALARM_CYCLES (ALARM_CYCLES),
        .MAX_FAIL     (MAX_FAIL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: mode name plus cycles remaining in that mode, fail count as plain integer.
    string m_mode = "LOCKED";
    int    m_left = 0;
    int    m_fail = 0;
    logic [7:0] exp_q[$];
    int    open_run  = 0;
    int    alarm_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mode_code(input string m);
        if (m == "CHECK") return 1;
        if (m == "OPEN")  return 2;
        if (m == "ALARM") return 3;
        return 0;
    endfunction

    task automatic model_edge(input logic en, input logic cr, input logic rs);
        int code;
        if (!rs) begin
            m_mode = "LOCKED"; m_left = 0; m_fail = 0;
        end else if (m_mode == "LOCKED") begin
            if (en) m_mode = "CHECK";
        end else if (m_mode == "CHECK") begin
            if (cr) begin
                m_mode = "OPEN"; m_left = OPEN_CYCLES; m_fail = 0;
            end else if (m_fail + 1 >= MAX_FAIL) begin
                m_mode = "ALARM"; m_left = ALARM_CYCLES; m_fail = MAX_FAIL;
            end else begin
                m_mode = "LOCKED"; m_fail = m_fail + 1;
            end
        end else if (m_mode == "OPEN") begin
            m_left = m_left - 1;
`ifdef LOCK_RELOCK_KEY_EN
            if (en) m_left = 0;
`endif
            if (m_left == 0) m_mode = "LOCKED";
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_mode = "LOCKED"; m_fail = 0;
            end
        end
        code = mode_code(m_mode);
        exp_q.push_back({2'(code), 3'(m_fail), (code == 1 || code == 3), (code == 3), (code == 2)});
    endtask

    task automatic compare_outputs();
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("state",    32'(bus.state),    32'(e[7:6]));
        check("fail_cnt", 32'(bus.fail_cnt), 32'(e[5:3]));
        check("busy",     32'(bus.busy),     32'(e[2]));
        check("alarm",    32'(bus.alarm),    32'(e[1]));
        check("unlock",   32'(bus.unlock),   32'(e[0]));
        if (bus.unlock === 1'b1) open_run++;
        if (bus.alarm === 1'b1) alarm_run++;
    endtask

    task automatic step(input logic en, input logic cr, input logic rs);
        bus.enter_trig = en;
        bus.com_result = cr;
        rst_n          = rs;
        @(posedge clk);
        model_edge(en, cr, rs);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic entry(input logic ok);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, ok, 1'b1);
    endtask

    initial begin
        bus.enter_trig = 1'b0;
        bus.com_result = 1'b0;
        rst_n          = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle(3);

        // Correct code: open for exactly OPEN_CYCLES, then relock
        open_run = 0;
        entry(1'b1);
        idle(OPEN_CYCLES + 2);
        check("unlock_len", 32'(open_run), 32'(OPEN_CYCLES));

        // Two wrong entries then a right one
        entry(1'b0);
        check("fail_after_1", 32'(bus.fail_cnt), 32'd1);
        entry(1'b0);
        check("fail_after_2", 32'(bus.fail_cnt), 32'd2);
        entry(1'b1);
        check("fail_cleared", 32'(bus.fail_cnt), 32'd0);
        idle(OPEN_CYCLES + 1);

        // Three wrong entries: alarm lockout, entries ignored meanwhile
        alarm_run = 0;
        entry(1'b0);
        entry(1'b0);
        entry(1'b0);
        for (int i = 0; i < ALARM_CYCLES + 2; i++) step(1'(i % 2), 1'b1, 1'b1);
        check("alarm_len", 32'(alarm_run), 32'(ALARM_CYCLES));
        idle(2);

        // Reset while OPEN with two cycles left on the hold timer
        entry(1'b1);
        idle(1);
        step(1'b0, 1'b0, 1'b0);
        check("rst_open_unlock", 32'(bus.unlock), 32'd0);
        idle(2);

        // Reset while in ALARM
        entry(1'b0); entry(1'b0); entry(1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0);
        check("rst_alarm_fail", 32'(bus.fail_cnt), 32'd0);
        idle(2);

        // enter_trig held through CHECK and OPEN
        open_run = 0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < OPEN_CYCLES; i++) step(1'b1, 1'b0, 1'b1);
        idle(ALARM_CYCLES + 2);
`ifdef LOCK_RELOCK_KEY_EN
        check("held_open_len", 32'(open_run), 32'd1);
`else
        check("held_open_len", 32'(open_run), 32'(OPEN_CYCLES));
`endif
        step(1'b0, 1'b0, 1'b0);

        // Key press on the second OPEN cycle
        entry(1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(OPEN_CYCLES + 1);

        // Random entries, results and occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 30), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) >= 2));
        end
        idle(ALARM_CYCLES + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
